adder_tree_stream: RTL and testbench

ADDER_TREE_STREAM -- requirements
Module: adder_tree_stream

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_tree_level.sv | 50 +++++
 rtl/adder_tree_stream.sv | 145 ++++++++++++++
 tb/tb_adder_tree_stream.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// +----------------------------------------------------------------------------+
// | adder_pkg : shared types and helpers for the adder_tree_stream block       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package adder_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } acc_state_t;

  localparam int c_BEATS_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_tree_level.sv
// +----------------------------------------------------------------------------+
// | adder_tree_level : one registered level of pairwise adds, one bit wider    |
// | Revision         : 1.0 - initial release                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module adder_tree_level #(
  parameter int WIDTH = 8,
  parameter int PAIRS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  input  logic [2*PAIRS*WIDTH-1:0]   data_i,
  output logic                       valid_o,
  output logic                       last_o,
  output logic [PAIRS*(WIDTH+1)-1:0] data_o
);

  logic [PAIRS*(WIDTH+1)-1:0] sum_d;
  logic [PAIRS*(WIDTH+1)-1:0] sum_q;
  logic                       valid_q;
  logic                       last_q;

  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    assign sum_d[p*(WIDTH+1) +: WIDTH+1] = {1'b0, data_i[2*p*WIDTH +: WIDTH]}
                                         + {1'b0, data_i[(2*p+1)*WIDTH +: WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sum_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      last_q  <= valid_i & last_i;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = sum_q;

endmodule

`default_nettype wire

// File: rtl/adder_tree_stream.sv
// +----------------------------------------------------------------------------+
// | adder_tree_stream : streaming adder tree feeding a framed accumulator      |
// | Option ADDER_TREE_SAT_EN : saturate the accumulator instead of wrapping    |
// | Revision          : 1.0 - initial release                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module adder_tree_stream
  import adder_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int NUM      = 32,
  parameter int ACC_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM*BITS-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_BITS-1:0]  out_data,
  output logic [15:0]          out_beats,
  output logic                 out_ovf
);

  localparam int L  = clog2(NUM);
  localparam int TW = BITS + L;

  acc_state_t             state_q, state_d;
  logic [ACC_BITS-1:0]    acc_q, acc_d;
  logic [c_BEATS_W-1:0]   beats_q, beats_d;
  logic                   ovf_q, ovf_d;

  logic                   w_en;
  logic                   w_tv;
  logic                   w_tl;
  logic [TW-1:0]          w_ts;
  logic [ACC_BITS-1:0]    w_base_acc;
  logic [c_BEATS_W-1:0]   w_base_beats;
  logic                   w_base_ovf;
  logic [ACC_BITS:0]      w_sum;

  // The whole pipeline freezes only while a result waits on downstream.
  assign w_en     = !(state_q == EMIT && !out_ready);
  assign in_ready = w_en;

  for (genvar n = 0; n < L; n++) begin : g_lvl
    localparam int W = BITS + n;
    localparam int P = NUM >> (n + 1);

    logic [2*P*W-1:0]   w_in;
    logic               w_in_v;
    logic               w_in_l;
    logic [P*(W+1)-1:0] w_out;
    logic               w_out_v;
    logic               w_out_l;

    if (n == 0) begin : g_first
      assign w_in   = in_data;
      assign w_in_v = in_valid;
      assign w_in_l = in_last;
    end else begin : g_next
      assign w_in   = g_lvl[n-1].w_out;
      assign w_in_v = g_lvl[n-1].w_out_v;
      assign w_in_l = g_lvl[n-1].w_out_l;
    end

    adder_tree_level #(
      .WIDTH (W),
      .PAIRS (P)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .en_i    (w_en),
      .valid_i (w_in_v),
      .last_i  (w_in_l),
      .data_i  (w_in),
      .valid_o (w_out_v),
      .last_o  (w_out_l),
      .data_o  (w_out)
    );
  end

  assign w_tv = g_lvl[L-1].w_out_v;
  assign w_tl = g_lvl[L-1].w_out_l;
  assign w_ts = g_lvl[L-1].w_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    beats_d      = beats_q;
    ovf_d        = ovf_q;
    w_base_acc   = acc_q;
    w_base_beats = beats_q;
    w_base_ovf   = ovf_q;
    w_sum        = '0;
    if (w_en) begin
      // Leaving EMIT means the result was taken, so the next frame starts from zero.
      if (state_q == EMIT) begin
        w_base_acc   = '0;
        w_base_beats = '0;
        w_base_ovf   = 1'b0;
      end
      state_d = ACCUM;
      acc_d   = w_base_acc;
      beats_d = w_base_beats;
      ovf_d   = w_base_ovf;
      if (w_tv) begin
        w_sum = {1'b0, w_base_acc} + (ACC_BITS+1)'(w_ts);
`ifdef ADDER_TREE_SAT_EN
        acc_d = w_sum[ACC_BITS] ? '1 : w_sum[ACC_BITS-1:0];
`else
        acc_d = w_sum[ACC_BITS-1:0];
`endif
        beats_d = (w_base_beats == '1) ? w_base_beats : w_base_beats + 1'b1;
        ovf_d   = w_base_ovf | w_sum[ACC_BITS];
        if (w_tl) state_d = EMIT;
      end
    end
  end

  assign out_valid = (state_q == EMIT);
  assign out_data  = acc_q;
  assign out_beats = beats_q;
  assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_tree_stream.sv
// +----------------------------------------------------------------------------+
// | tb_adder_tree_stream : directed self-checking bench for adder_tree_stream  |
// | Revision             : 1.0 - initial release                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_adder_tree_stream;

  localparam int c_NUM = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, default parameters
  logic                 m_in_valid = 1'b0, m_in_last = 1'b0, m_out_ready = 1'b1;
  logic [c_NUM*8-1:0]   m_in_data = '0;
  logic                 m_in_ready, m_out_valid, m_out_ovf;
  logic [23:0]          m_out_data;
  logic [15:0]          m_out_beats;

  // narrow accumulator instance
  logic                 o_in_valid = 1'b0, o_in_last = 1'b0, o_out_ready = 1'b1;
  logic [c_NUM*8-1:0]   o_in_data = '0;
  logic                 o_in_ready, o_out_valid, o_out_ovf;
  logic [12:0]          o_out_data;
  logic [15:0]          o_out_beats;

  // four-element instance for the random stall run
  logic                 r_in_valid = 1'b0, r_in_last = 1'b0, r_out_ready = 1'b1;
  logic [31:0]          r_in_data = '0;
  logic                 r_in_ready, r_out_valid, r_out_ovf;
  logic [23:0]          r_out_data;
  logic [15:0]          r_out_beats;

  adder_tree_stream dut (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(m_in_data), .in_last(m_in_last), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_data(m_out_data), .out_beats(m_out_beats),
    .out_ovf(m_out_ovf)
  );

  adder_tree_stream #(.BITS(8), .NUM(32), .ACC_BITS(13)) dut_ovf (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_data(o_in_data), .in_last(o_in_last), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .out_data(o_out_data), .out_beats(o_out_beats),
    .out_ovf(o_out_ovf)
  );

  adder_tree_stream #(.BITS(8), .NUM(4), .ACC_BITS(24)) dut_rnd (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_data(r_in_data), .in_last(r_in_last), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .out_data(r_out_data), .out_beats(r_out_beats),
    .out_ovf(r_out_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rdy_bad  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_beat(input logic [7:0] b, input logic last);
    m_in_valid = 1'b1;
    m_in_data  = {c_NUM{b}};
    m_in_last  = last;
    #1;
    if (m_in_ready !== 1'b1) rdy_bad++;
    @(negedge clk);
    m_in_valid = 1'b0;
    m_in_last  = 1'b0;
  endtask

  task automatic m_wait(output int n);
    n = 1;
    while (m_out_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int lat, bi, stall_n, stall_bad, nres, quiet_bad;
    logic released, took;
    logic [23:0] res_d [2];
    logic [15:0] res_b [2];
    int fsent, nb, bidx, rres, rbad;
    logic [23:0] racc;
    logic [15:0] rbeats;
    logic [39:0] expq [$];
    logic [39:0] e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", m_out_valid, 0);
    check_eq("rst_out_data",  m_out_data,  0);
    check_eq("rst_out_beats", m_out_beats, 0);
    check_eq("rst_out_ovf",   m_out_ovf,   0);
    check_eq("rst_in_ready",  m_in_ready,  1);

    // single beat of 0xFF
    m_beat(8'hFF, 1'b1);
    m_wait(lat);
    check_eq("ff_latency", lat, 6);
    check_eq("ff_valid",   m_out_valid, 1);
    check_eq("ff_data",    m_out_data, 8160);
    check_eq("ff_beats",   m_out_beats, 1);
    check_eq("ff_ovf",     m_out_ovf, 0);
    @(negedge clk);

    // four back-to-back beats of 0x01
    rdy_bad = 0;
    for (int i = 0; i < 4; i++) m_beat(8'h01, i == 3);
    check_eq("b2b_in_ready_bad", rdy_bad, 0);
    m_wait(lat);
    check_eq("b2b_latency", lat, 6);
    check_eq("b2b_data",  m_out_data, 128);
    check_eq("b2b_beats", m_out_beats, 4);
    @(negedge clk);

    // result held off for 10 cycles while the next frame keeps arriving
    m_out_ready = 1'b0;
    m_beat(8'h03, 1'b1);
    bi = 0; stall_n = 0; stall_bad = 0; nres = 0; released = 1'b0;
    res_d[0] = '0; res_d[1] = '0; res_b[0] = '0; res_b[1] = '0;
    for (int cyc = 0; cyc < 80 && nres < 2; cyc++) begin
      m_in_valid = (bi < 8);
      m_in_data  = {c_NUM{8'h01}};
      m_in_last  = (bi == 7);
      if (m_out_valid && !released && stall_n == 10) begin
        released    = 1'b1;
        m_out_ready = 1'b1;
      end
      #1;
      if (m_out_valid && !released) begin
        stall_n++;
        if (m_in_ready !== 1'b0 || m_out_data !== 24'd96 || m_out_beats !== 16'd1) stall_bad++;
      end
      if (m_out_valid && m_out_ready) begin
        res_d[nres] = m_out_data;
        res_b[nres] = m_out_beats;
        nres++;
      end
      took = m_in_valid && m_in_ready;
      @(negedge clk);
      if (took) bi++;
    end
    m_in_valid = 1'b0; m_in_last = 1'b0; m_out_ready = 1'b1;
    check_eq("stall_cycles", stall_n, 10);
    check_eq("stall_stable_bad", stall_bad, 0);
    check_eq("stall_nres", nres, 2);
    check_eq("stall_a_data",  res_d[0], 96);
    check_eq("stall_a_beats", res_b[0], 1);
    check_eq("stall_b_data",  res_d[1], 256);
    check_eq("stall_b_beats", res_b[1], 8);
    @(negedge clk);

    // reset while a frame is in flight
    for (int i = 0; i < 3; i++) m_beat(8'h01, i == 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (m_out_valid !== 1'b0) quiet_bad++;
      @(negedge clk);
    end
    check_eq("rst_flush_quiet", quiet_bad, 0);
    m_beat(8'h02, 1'b1);
    m_wait(lat);
    check_eq("post_rst_valid", m_out_valid, 1);
    check_eq("post_rst_data",  m_out_data, 64);
    check_eq("post_rst_beats", m_out_beats, 1);
    @(negedge clk);

    // 13-bit accumulator overflow, three beats of 0xFF = 24480
    for (int i = 0; i < 3; i++) begin
      o_in_valid = 1'b1;
      o_in_data  = {c_NUM{8'hFF}};
      o_in_last  = (i == 2);
      @(negedge clk);
    end
    o_in_valid = 1'b0; o_in_last = 1'b0;
    lat = 0;
    while (o_out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ovf_valid", o_out_valid, 1);
    check_eq("ovf_flag",  o_out_ovf, 1);
    check_eq("ovf_beats", o_out_beats, 3);
`ifdef ADDER_TREE_SAT_EN
    check_eq("ovf_data_sat",  o_out_data, 8191);
`else
    check_eq("ovf_data_wrap", o_out_data, 8096);
`endif
    @(negedge clk);

    // random valid / ready pattern on the four-element instance
    fsent = 0; bidx = 0; rres = 0; rbad = 0; racc = '0; rbeats = '0;
    nb = $urandom_range(1, 4);
    for (int cyc = 0; cyc < 40000 && rres < 1000; cyc++) begin
      r_out_ready = ($urandom_range(0, 3) != 0);
      r_in_valid  = (fsent < 1000) && ($urandom_range(0, 3) != 0);
      r_in_data   = $urandom;
      r_in_last   = (bidx == nb - 1);
      #1;
      if (r_out_valid && r_out_ready) begin
        if (expq.size() == 0) rbad++;
        else begin
          e = expq.pop_front();
          if (r_out_data !== e[23:0] || r_out_beats !== e[39:24] || r_out_ovf !== 1'b0) rbad++;
        end
        rres++;
      end
      if (r_in_valid && r_in_ready) begin
        racc = racc + r_in_data[7:0] + r_in_data[15:8] + r_in_data[23:16] + r_in_data[31:24];
        rbeats++;
        if (r_in_last) begin
          expq.push_back({rbeats, racc});
          fsent++;
          racc = '0; rbeats = '0; bidx = 0;
          nb = $urandom_range(1, 4);
        end else begin
          bidx++;
        end
      end
      @(negedge clk);
    end
    r_in_valid = 1'b0;
    check_eq("rnd_results", rres, 1000);
    check_eq("rnd_bad", rbad, 0);
    check_eq("rnd_leftover", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
